// File: rtl/reservoir_pkg.sv
// Shared constants and helper functions for the reservoir level controller.
package reservoir_pkg;

  localparam int DEF_N_LEVELS        = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_MIN_ON_CYCLES   = 8;

  // Width needed to hold a band number in 0..n.
  function automatic int lw_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Helpers take an 8-bit vector, which covers the widest supported sensor set.
  function automatic int popcount(input logic [7:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  // A valid thermometer code has every set bit below every clear bit.
  function automatic logic thermo_valid(input logic [7:0] v);
    logic [8:0] mask;
    mask = (9'd1 << popcount(v)) - 9'd1;
    return v == mask[7:0];
  endfunction

  // Index of the highest set bit plus one, or 0 when no bit is set.
  function automatic int highest_band(input logic [7:0] v);
    int b;
    b = 0;
    for (int i = 0; i < 8; i++) if (v[i]) b = i + 1;
    return b;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Single-bit debounce filter: the output follows the raw input only after it
// has disagreed for DEBOUNCE_CYCLES consecutive samples.
module sensor_debounce
  import reservoir_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filtered <= 1'b1;
      cnt      <= '0;
    end else if (raw == filtered) begin
      cnt <= '0;
    end else if (int'(cnt) == DEBOUNCE_CYCLES - 1) begin
      filtered <= raw;
      cnt      <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/reservoir_level_controller.sv
// Debounced N-sensor reservoir level tracker with staged fill pumps, per-pump
// minimum-on hold and latched alarm. Optional macro RESERVOIR_FAULT_DETECT_EN
// adds thermometer-code fault detection with alarm and pump override.
module reservoir_level_controller
  import reservoir_pkg::*;
#(
  parameter  int N_LEVELS        = DEF_N_LEVELS,
  parameter  int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter  int MIN_ON_CYCLES   = DEF_MIN_ON_CYCLES,
  localparam int LW              = lw_width(N_LEVELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_LEVELS-1:0] sensor,
  input  logic                alarm_ack,
  output logic [LW-1:0]       level,
  output logic [N_LEVELS-1:0] pump_en,
  output logic                alarm,
  output logic                sensor_fault
);

  localparam int CW = (MIN_ON_CYCLES > 0) ? $clog2(MIN_ON_CYCLES + 1) : 1;

  logic [N_LEVELS-1:0] filtered;
  logic                fault;
  logic [LW-1:0]       target;
  logic [LW-1:0]       level_next;
  logic [N_LEVELS-1:0] pump_next;
  logic [CW-1:0]       on_cnt      [N_LEVELS];
  logic [CW-1:0]       on_cnt_next [N_LEVELS];
  logic                alarm_cond;

  for (genvar g = 0; g < N_LEVELS; g++) begin : g_deb
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .reset    (reset),
      .raw      (sensor[g]),
      .filtered (filtered[g])
    );
  end

`ifdef RESERVOIR_FAULT_DETECT_EN
  assign fault  = !thermo_valid(8'(filtered));
  assign target = LW'(popcount(8'(filtered)));
`else
  assign fault  = 1'b0;
  assign target = LW'(highest_band(8'(filtered)));
`endif

  // NOTE: every always_comb output gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    level_next = level;
    if (!fault) begin
      if (level < target)      level_next = level + LW'(1);
      else if (level > target) level_next = level - LW'(1);
    end
  end

  // A pump stays on if demanded, forced by a fault, or still inside its hold.
  always_comb begin
    for (int i = 0; i < N_LEVELS; i++) begin
      pump_next[i]   = fault
                     || (i < N_LEVELS - int'(level))
                     || (pump_en[i] && (int'(on_cnt[i]) + 1 < MIN_ON_CYCLES));
      on_cnt_next[i] = '0;
      if (pump_next[i] && pump_en[i] && (int'(on_cnt[i]) < MIN_ON_CYCLES))
        on_cnt_next[i] = on_cnt[i] + CW'(1);
      else if (pump_next[i] && pump_en[i])
        on_cnt_next[i] = on_cnt[i];
    end
  end

  assign alarm_cond = (level == '0) || fault;

  // NOTE: the on-counter array is reset with the rest of the state because a
  // stale count after reset would shorten the first hold of each pump.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level        <= LW'(N_LEVELS);
      pump_en      <= '0;
      alarm        <= 1'b0;
      sensor_fault <= 1'b0;
      on_cnt       <= '{default: '0};
    end else begin
      level        <= level_next;
      pump_en      <= pump_next;
      sensor_fault <= fault;
      on_cnt       <= on_cnt_next;
      if (alarm_cond)     alarm <= 1'b1;
      else if (alarm_ack) alarm <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reservoir_level_controller.sv
// Self-checking bench for reservoir_level_controller at default parameters.
module tb_reservoir_level_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sensor;
  logic       alarm_ack;
  logic [1:0] level;
  logic [2:0] pump_en;
  logic       alarm;
  logic       sensor_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reservoir_level_controller #(
    .N_LEVELS(3), .DEBOUNCE_CYCLES(4), .MIN_ON_CYCLES(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sensor       (sensor),
    .alarm_ack    (alarm_ack),
    .level        (level),
    .pump_en      (pump_en),
    .alarm        (alarm),
    .sensor_fault (sensor_fault)
  );

  typedef struct {
    logic [2:0] sensor;
    int         hold;
    logic [1:0] level;
    logic [2:0] pump;
    logic       alarm;
  } vec_t;

  typedef struct {
    logic [1:0] level;
    logic [2:0] pump;
    logic       alarm;
  } exp_t;

  exp_t sb[$];
  vec_t drain[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack;
    alarm_ack = 1'b1;
    cycles(1);
    alarm_ack = 1'b0;
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    sensor    = 3'b111;
    alarm_ack = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    int on_n;
    exp_t e;

    drain[0] = '{3'b111, 10, 2'd3, 3'b000, 1'b0};
    drain[1] = '{3'b011, 10, 2'd2, 3'b001, 1'b0};
    drain[2] = '{3'b001, 10, 2'd1, 3'b011, 1'b0};
    drain[3] = '{3'b000, 10, 2'd0, 3'b111, 1'b1};

    // Reset state while reset is held
    reset = 1'b1; sensor = 3'b000; alarm_ack = 1'b0;
    cycles(2);
    check("reset_level", level, 3);
    check("reset_pump", pump_en, 0);
    check("reset_alarm", alarm, 0);
    check("reset_fault", sensor_fault, 0);
    sensor = 3'b111;
    reset  = 1'b0;
    cycles(2);

    // Drain table
    for (int i = 0; i < 4; i++) begin
      sensor = drain[i].sensor;
      sb.push_back('{drain[i].level, drain[i].pump, drain[i].alarm});
      cycles(drain[i].hold);
      e = sb.pop_front();
      check($sformatf("drain%0d_level", i), level, e.level);
      check($sformatf("drain%0d_pump", i), pump_en, e.pump);
      check($sformatf("drain%0d_alarm", i), alarm, e.alarm);
      check($sformatf("drain%0d_fault", i), sensor_fault, 0);
    end

    // Ack while the condition holds is ignored and not remembered
    pulse_ack();
    check("ack_ignored", alarm, 1);
    sensor = 3'b001;
    cycles(10);
    check("refill_level", level, 1);
    check("refill_pump", pump_en, 3'b011);
    check("refill_alarm_held", alarm, 1);
    pulse_ack();
    check("ack_clears", alarm, 0);

    // Async reset mid-drain at level 1 with pumps on
    alarm_ack = 1'b0;
    check("pre_reset_pump", pump_en, 3'b011);
    #2 reset = 1'b1;
    #1;
    check("midreset_level", level, 3);
    check("midreset_pump", pump_en, 0);
    check("midreset_alarm", alarm, 0);
    check("midreset_fault", sensor_fault, 0);
    @(negedge clk);
    sensor = 3'b111;
    reset  = 1'b0;
    cycles(2);

    // Glitch shorter than the debounce window never reaches level
    sensor = 3'b011;
    cycles(3);
    sensor = 3'b111;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("glitch_level_%0d", i), level, 3);
      check($sformatf("glitch_pump_%0d", i), pump_en, 0);
      cycles(1);
    end

    // Min-on hold: pump 0 on for 8 cycles in total
    do_reset();
    sensor = 3'b011;
    t = 0;
    while (pump_en[0] !== 1'b1 && t < 20) begin
      cycles(1);
      t++;
    end
    check("minon_engage_in_time", (t < 20), 1);
    on_n = 0;
    while (pump_en[0] === 1'b1 && on_n < 40) begin
      on_n++;
      cycles(1);
      if (on_n == 2) sensor = 3'b111;
    end
    check("minon_cycles", on_n, 8);
    check("minon_level", level, 3);
    check("minon_pump_off", pump_en, 0);

`ifdef RESERVOIR_FAULT_DETECT_EN
    // Non-thermometer pattern forces pumps and alarm, level held
    do_reset();
    sensor = 3'b101;
    t = 0;
    while (sensor_fault !== 1'b1 && t < 20) begin
      cycles(1);
      t++;
    end
    check("fault_seen_in_time", (t < 20), 1);
    check("fault_pump", pump_en, 3'b111);
    check("fault_alarm", alarm, 1);
    check("fault_level_held", level, 3);
    pulse_ack();
    check("fault_ack_ignored", alarm, 1);
    sensor = 3'b111;
    t = 0;
    while (sensor_fault !== 1'b0 && t < 20) begin
      cycles(1);
      t++;
    end
    check("fault_clear_in_time", (t < 20), 1);
    cycles(2);
    check("fault_alarm_until_ack", alarm, 1);
    pulse_ack();
    check("fault_ack_clears", alarm, 0);
`else
    // Without fault detection the highest set bit decides the band
    do_reset();
    sensor = 3'b101;
    cycles(10);
    check("nofault_level", level, 3);
    check("nofault_pump", pump_en, 0);
    check("nofault_flag", sensor_fault, 0);
    check("nofault_alarm", alarm, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
